// File: rtl/addr_trans_pipe_pkg.sv
// Shared types for the address translation pipeline: TLB entry layout,
// exception codes and translation mode encodings.
package addr_trans_pipe_pkg;

    // One TLB entry; 4 KB pages only.
    typedef struct packed {
        logic [19:0] vppn;
        logic [9:0]  asid;
        logic        g;
        logic        v;
        logic        d;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic [19:0] ppn;
    } tlb_entry_t;

    // Translation exception codes carried on rsp_exc.
    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_TLBR = 3'd1,
        EXC_PIL  = 3'd2,
        EXC_PIS  = 3'd3,
        EXC_PPI  = 3'd4,
        EXC_PME  = 3'd5
    } exc_e;

    // Translation mode encodings on dapg; anything other than mapped acts as direct.
    localparam logic [1:0] MODE_DIRECT = 2'b01;
    localparam logic [1:0] MODE_MAPPED = 2'b10;

endpackage

// File: rtl/addr_trans_lookup.sv
// Combinational translation of one virtual address: direct mode, then
// direct-mapped windows, then the fully-associative TLB with permission checks.
module addr_trans_lookup
    import addr_trans_pipe_pkg::*;
#(
    parameter int NDMW = 2,
    parameter int NTLB = 8
) (
    input  logic [1:0]             dapg,
    input  logic [NDMW*32-1:0]     dmw,
    input  logic [1:0]             plv,
    input  logic [9:0]             asid,
    input  logic [31:0]            vaddr,
    input  logic                   store,
    input  logic [NTLB-1:0]        tlb_valid,
    input  tlb_entry_t [NTLB-1:0]  tlb,
    output logic [31:0]            paddr,
    output logic                   uncached,
    output exc_e                   exc
);

    logic        dmw_hit;
    logic [31:0] dmw_paddr;
    logic        dmw_uncached;
    logic        tlb_hit;
    tlb_entry_t  hit_entry;
    logic [NDMW-1:0] unused_dmw;

    // Window match; scanning from the top down lets the lowest index win.
    always_comb begin
        dmw_hit      = 1'b0;
        dmw_paddr    = '0;
        dmw_uncached = 1'b0;
        unused_dmw   = '0;
        for (int w = NDMW - 1; w >= 0; w--) begin
            if ((dmw[w*32+29 +: 3] == vaddr[31:29]) &&
                ((plv == 2'd0 && dmw[w*32]) || (plv == 2'd3 && dmw[w*32+3]))) begin
                dmw_hit      = 1'b1;
                dmw_paddr    = {dmw[w*32+25 +: 3], vaddr[28:0]};
                dmw_uncached = (dmw[w*32+4 +: 2] == 2'b00);
            end
            // Reserved CSR bits play no part in translation.
            unused_dmw[w] = ^{dmw[w*32+1 +: 2], dmw[w*32+6 +: 19]};
        end
    end

    // TLB match on present entries; top-down scan so the lowest index wins.
    always_comb begin
        tlb_hit   = 1'b0;
        hit_entry = '0;
        for (int i = NTLB - 1; i >= 0; i--) begin
            if (tlb_valid[i] && (tlb[i].vppn == vaddr[31:12]) &&
                (tlb[i].g || (tlb[i].asid == asid))) begin
                tlb_hit   = 1'b1;
                hit_entry = tlb[i];
            end
        end
    end

    // Final result; any exception passes vaddr through as an uncached address.
    always_comb begin
        paddr    = vaddr;
        uncached = 1'b1;
        exc      = EXC_NONE;
        if (dapg != MODE_MAPPED) begin
            uncached = 1'b0;
        end else if (dmw_hit) begin
            paddr    = dmw_paddr;
            uncached = dmw_uncached;
        end else if (!tlb_hit) begin
            exc = EXC_TLBR;
        end else if (!hit_entry.v) begin
            exc = store ? EXC_PIS : EXC_PIL;
        end else if (plv > hit_entry.plv) begin
            exc = EXC_PPI;
        end else if (store && !hit_entry.d) begin
            exc = EXC_PME;
        end else begin
            paddr    = {hit_entry.ppn, vaddr[11:0]};
            uncached = (hit_entry.mat == 2'b00);
        end
    end

endmodule

// File: rtl/addr_trans_pipe.sv
// Multi-channel address translation pipeline: a shared TLB plus one
// registered request/response stage per channel (channel 0 inst, 1 data).
module addr_trans_pipe
    import addr_trans_pipe_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int NDMW = 2,
    parameter int NTLB = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               dapg,
    input  logic [NDMW*32-1:0]       dmw,
    input  logic [1:0]               plv,
    input  logic [9:0]               asid,
    input  logic [NCH-1:0]           req_valid,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH*32-1:0]        req_vaddr,
    input  logic [NCH-1:0]           req_store,
    output logic [NCH-1:0]           rsp_valid,
    input  logic [NCH-1:0]           rsp_ready,
    output logic [NCH*32-1:0]        rsp_paddr,
    output logic [NCH-1:0]           rsp_uncached,
    output logic [NCH*3-1:0]         rsp_exc,
    input  logic                     tlb_we,
    input  logic [$clog2(NTLB)-1:0]  tlb_idx,
    input  tlb_entry_t               tlb_wdata,
    input  logic                     tlb_inv_all
);

    tlb_entry_t [NTLB-1:0] tlb_q;
    logic [NTLB-1:0]       tlb_valid_q;

    // Entry presence bits; invalidate-all beats a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tlb_valid_q <= '0;
        end else if (tlb_inv_all) begin
            tlb_valid_q <= '0;
        end else if (tlb_we) begin
            tlb_valid_q[tlb_idx] <= 1'b1;
        end
    end

    // Entry contents; only meaningful once the presence bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (reset && !tlb_inv_all && tlb_we) begin
            tlb_q[tlb_idx] <= tlb_wdata;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [31:0] xl_paddr;
        logic        xl_uncached;
        exc_e        xl_exc;
        logic        vld_p1;
        logic [31:0] paddr_p1;
        logic        uncached_p1;
        exc_e        exc_p1;

        // Lookup sees the TLB as registered before this edge's write/invalidate.
        addr_trans_lookup #(
            .NDMW (NDMW),
            .NTLB (NTLB)
        ) u_lookup (
            .dapg      (dapg),
            .dmw       (dmw),
            .plv       (plv),
            .asid      (asid),
            .vaddr     (req_vaddr[c*32 +: 32]),
            .store     (req_store[c]),
            .tlb_valid (tlb_valid_q),
            .tlb       (tlb_q),
            .paddr     (xl_paddr),
            .uncached  (xl_uncached),
            .exc       (xl_exc)
        );

        assign req_ready[c]          = !vld_p1 || rsp_ready[c];
        assign rsp_valid[c]          = vld_p1;
        assign rsp_paddr[c*32 +: 32] = paddr_p1;
        assign rsp_uncached[c]       = uncached_p1;
        assign rsp_exc[c*3 +: 3]     = exc_p1;

        // ---- stage p1: response register, holds while stalled ----
        always_ff @(posedge clk) begin
            if (!reset) begin
                vld_p1      <= 1'b0;
                paddr_p1    <= '0;
                uncached_p1 <= 1'b0;
                exc_p1      <= EXC_NONE;
            end else if (req_ready[c]) begin
                vld_p1 <= req_valid[c];
                if (req_valid[c]) begin
                    paddr_p1    <= xl_paddr;
                    uncached_p1 <= xl_uncached;
                    exc_p1      <= xl_exc;
                end
            end
        end
    end

endmodule

// File: tb/tb_addr_trans_pipe.sv
// Bench for addr_trans_pipe: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_addr_trans_pipe;
    import addr_trans_pipe_pkg::*;

    localparam int NCH  = 2;
    localparam int NDMW = 2;
    localparam int NTLB = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          dapg;
    logic [NDMW*32-1:0]  dmw;
    logic [1:0]          plv;
    logic [9:0]          asid;
    logic [NCH-1:0]      req_valid;
    logic [NCH-1:0]      req_ready;
    logic [NCH*32-1:0]   req_vaddr;
    logic [NCH-1:0]      req_store;
    logic [NCH-1:0]      rsp_valid;
    logic [NCH-1:0]      rsp_ready;
    logic [NCH*32-1:0]   rsp_paddr;
    logic [NCH-1:0]      rsp_uncached;
    logic [NCH*3-1:0]    rsp_exc;
    logic                tlb_we;
    logic [2:0]          tlb_idx;
    tlb_entry_t          tlb_wdata;
    logic                tlb_inv_all;

    addr_trans_pipe #(.NCH(NCH), .NDMW(NDMW), .NTLB(NTLB)) dut (
        .clk          (clk),
        .reset        (reset),
        .dapg         (dapg),
        .dmw          (dmw),
        .plv          (plv),
        .asid         (asid),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_vaddr    (req_vaddr),
        .req_store    (req_store),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_paddr    (rsp_paddr),
        .rsp_uncached (rsp_uncached),
        .rsp_exc      (rsp_exc),
        .tlb_we       (tlb_we),
        .tlb_idx      (tlb_idx),
        .tlb_wdata    (tlb_wdata),
        .tlb_inv_all  (tlb_inv_all)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    tlb_entry_t  m_tlb [NTLB];
    logic        m_tv  [NTLB];
    logic        m_vld [NCH];
    logic [31:0] m_pa  [NCH];
    logic        m_unc [NCH];
    logic [2:0]  m_exc [NCH];
    int          n_acc [NCH];
    int          n_done[NCH];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Translation rules applied to the current CSRs and the model TLB.
    function automatic void model_xlate(input logic [31:0] va, input logic st,
                                        output logic [31:0] pa, output logic unc,
                                        output logic [2:0] exc);
        logic [31:0] w;
        tlb_entry_t  e;
        pa = va; unc = 1'b1; exc = EXC_NONE;
        if (dapg != 2'b10) begin
            unc = 1'b0;
            return;
        end
        for (int k = 0; k < NDMW; k++) begin
            w = dmw[k*32 +: 32];
            if (va[31:29] == w[31:29] && ((plv == 0 && w[0]) || (plv == 3 && w[3]))) begin
                pa = {w[27:25], va[28:0]};
                unc = (w[5:4] == 0);
                return;
            end
        end
        for (int i = 0; i < NTLB; i++) begin
            e = m_tlb[i];
            if (m_tv[i] && e.vppn == va[31:12] && (e.g || e.asid == asid)) begin
                if (!e.v)               exc = st ? EXC_PIS : EXC_PIL;
                else if (plv > e.plv)   exc = EXC_PPI;
                else if (st && !e.d)    exc = EXC_PME;
                else begin
                    pa = {e.ppn, va[11:0]};
                    unc = (e.mat == 0);
                end
                return;
            end
        end
        exc = EXC_TLBR;
    endfunction

    // One clock: check ready, advance model with current inputs, then compare outputs.
    task automatic cycle();
        logic [31:0] pa;
        logic        u;
        logic [2:0]  e;
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                chk($sformatf("req_ready%0d", c), req_ready[c], !m_vld[c] || rsp_ready[c]);
                if (rsp_valid[c] && rsp_ready[c]) n_done[c]++;
                if (req_valid[c] && req_ready[c]) n_acc[c]++;
            end
        end
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_vld[c] = 0; m_pa[c] = 0; m_unc[c] = 0; m_exc[c] = EXC_NONE;
            end
            for (int i = 0; i < NTLB; i++) m_tv[i] = 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (!m_vld[c] || rsp_ready[c]) begin
                    m_vld[c] = req_valid[c];
                    if (req_valid[c]) begin
                        model_xlate(req_vaddr[c*32 +: 32], req_store[c], pa, u, e);
                        m_pa[c] = pa; m_unc[c] = u; m_exc[c] = e;
                    end
                end
            end
            if (tlb_inv_all) begin
                for (int i = 0; i < NTLB; i++) m_tv[i] = 0;
            end else if (tlb_we) begin
                m_tlb[tlb_idx] = tlb_wdata;
                m_tv[tlb_idx]  = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("rsp_valid%0d", c),    rsp_valid[c],          m_vld[c]);
            chk($sformatf("rsp_paddr%0d", c),    rsp_paddr[c*32 +: 32], m_pa[c]);
            chk($sformatf("rsp_uncached%0d", c), rsp_uncached[c],       m_unc[c]);
            chk($sformatf("rsp_exc%0d", c),      rsp_exc[c*3 +: 3],     m_exc[c]);
        end
    endtask

    function automatic tlb_entry_t mk_entry(input logic v, input logic d);
        tlb_entry_t t;
        t.vppn = 20'h00040; t.asid = 10'd0; t.g = 1'b1; t.v = v; t.d = d;
        t.plv = 2'd3; t.mat = 2'd1; t.ppn = 20'h12345;
        return t;
    endfunction

    logic [19:0] vppns [4] = '{20'h00040, 20'h00041, 20'hA0001, 20'h80002};
    logic [2:0]  segs  [4] = '{3'd0, 3'd5, 3'd4, 3'd7};

    initial begin
        logic [31:0] t;
        tlb_entry_t  te;
        for (int c = 0; c < NCH; c++) begin
            m_vld[c] = 0; m_pa[c] = 0; m_unc[c] = 0; m_exc[c] = 0; n_acc[c] = 0; n_done[c] = 0;
        end
        for (int i = 0; i < NTLB; i++) begin m_tv[i] = 0; m_tlb[i] = '0; end
        reset = 0; dapg = MODE_DIRECT; dmw = '0; plv = 0; asid = 10'd1;
        req_valid = 2'b11; req_vaddr = {32'h1111_0000, 32'h2222_0000}; req_store = 0;
        rsp_ready = 2'b00; tlb_we = 0; tlb_idx = 0; tlb_wdata = '0; tlb_inv_all = 0;

        // Reset state
        cycle(); cycle();
        chk("lit_rst_valid", rsp_valid, 0);
        chk("lit_rst_paddr", rsp_paddr[31:0], 0);
        chk("lit_rst_unc", rsp_uncached, 0);
        chk("lit_rst_exc", rsp_exc, 0);
        reset = 1; req_valid = 0; rsp_ready = 2'b11;
        #1 chk("lit_ready_after_reset", req_ready, 2'b11);

        // Direct mode
        dapg = MODE_DIRECT; req_valid = 2'b01; req_vaddr[31:0] = 32'h1C00_0000;
        cycle();
        chk("lit_direct_valid", rsp_valid[0], 1);
        chk("lit_direct_paddr", rsp_paddr[31:0], 32'h1C00_0000);
        chk("lit_direct_unc", rsp_uncached[0], 0);
        chk("lit_direct_exc", rsp_exc[2:0], EXC_NONE);

        // DMW hit at plv 0, miss (empty TLB) at plv 3
        dapg = MODE_MAPPED; dmw = {32'h0, 32'hA000_0011}; plv = 0; req_vaddr[31:0] = 32'hA000_1234;
        cycle();
        chk("lit_dmw_paddr", rsp_paddr[31:0], 32'h0000_1234);
        chk("lit_dmw_unc", rsp_uncached[0], 0);
        plv = 3;
        cycle();
        chk("lit_dmw_plv3_exc", rsp_exc[2:0], EXC_TLBR);
        chk("lit_dmw_plv3_unc", rsp_uncached[0], 1);

        // TLB entry 3: hit, PME, PIL
        plv = 0; req_valid = 0;
        tlb_we = 1; tlb_idx = 3; tlb_wdata = mk_entry(1, 1);
        cycle();
        tlb_we = 0; req_valid = 2'b10; req_vaddr[63:32] = 32'h0004_0ABC; req_store = 0;
        cycle();
        chk("lit_tlb_paddr", rsp_paddr[63:32], 32'h1234_5ABC);
        chk("lit_tlb_exc", rsp_exc[5:3], EXC_NONE);
        req_valid = 0; tlb_we = 1; tlb_wdata = mk_entry(1, 0);
        cycle();
        tlb_we = 0; req_valid = 2'b10; req_store = 2'b10;
        cycle();
        chk("lit_pme_exc", rsp_exc[5:3], EXC_PME);
        chk("lit_pme_paddr", rsp_paddr[63:32], 32'h0004_0ABC);
        req_valid = 0; tlb_we = 1; tlb_wdata = mk_entry(0, 1);
        cycle();
        tlb_we = 0; req_valid = 2'b10; req_store = 0;
        cycle();
        chk("lit_pil_exc", rsp_exc[5:3], EXC_PIL);

        // Invalidate at the accept edge is not seen; the following lookup misses
        req_valid = 0; tlb_we = 1; tlb_wdata = mk_entry(1, 1);
        cycle();
        tlb_we = 0; req_valid = 2'b10; tlb_inv_all = 1;
        cycle();
        chk("lit_inv_same_paddr", rsp_paddr[63:32], 32'h1234_5ABC);
        chk("lit_inv_same_exc", rsp_exc[5:3], EXC_NONE);
        tlb_inv_all = 0;
        cycle();
        chk("lit_inv_next_exc", rsp_exc[5:3], EXC_TLBR);

        // Reset drops a pending response
        dapg = MODE_DIRECT; req_valid = 2'b01; rsp_ready = 0;
        cycle();
        chk("lit_pending_valid", rsp_valid[0], 1);
        req_valid = 0; reset = 0;
        cycle();
        chk("lit_reset_drop", rsp_valid, 0);
        reset = 1; rsp_ready = 2'b11;

        // Back-to-back on both channels with channel 1 ready toggling
        for (int c = 0; c < NCH; c++) begin n_acc[c] = 0; n_done[c] = 0; end
        for (int k = 0; k < 24; k++) begin
            for (int c = 0; c < NCH; c++) begin
                req_valid[c] = (n_acc[c] < 8);
                req_vaddr[c*32 +: 32] = 32'h1000_0000 + c * 32'h100 + n_acc[c] * 4;
            end
            rsp_ready = {k[0], 1'b1};
            cycle();
        end
        chk("lit_burst_acc0", n_acc[0], 8);
        chk("lit_burst_acc1", n_acc[1], 8);
        chk("lit_burst_done0", n_done[0], 8);
        chk("lit_burst_done1", n_done[1], 8);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            dapg  = 2'($urandom_range(0, 3));
            plv   = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
            asid  = 10'($urandom_range(1, 2));
            if ($urandom_range(0, 15) == 0) begin
                for (int w = 0; w < NDMW; w++) begin
                    t = $urandom();
                    t[31:29] = segs[$urandom_range(0, 3)];
                    dmw[w*32 +: 32] = t;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                req_valid[c] = ($urandom_range(0, 3) != 0);
                req_vaddr[c*32 +: 32] = {vppns[$urandom_range(0, 3)], 12'($urandom())};
                req_store[c] = 1'($urandom());
                rsp_ready[c] = ($urandom_range(0, 3) != 0);
            end
            tlb_we  = ($urandom_range(0, 3) == 0);
            tlb_idx = 3'($urandom());
            te.vppn = vppns[$urandom_range(0, 3)];
            te.asid = 10'($urandom_range(1, 2));
            te.g = 1'($urandom()); te.v = ($urandom_range(0, 3) != 0); te.d = 1'($urandom());
            te.plv = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
            te.mat = 2'($urandom()); te.ppn = 20'($urandom());
            tlb_wdata = te;
            tlb_inv_all = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_trans_pipe.md
ADDR_TRANS_PIPE -- requirements
Module: addr_trans_pipe

Interface
REQ-001 Parameter NCH, 2, number of independent translation channels (channel 0 = inst, channel 1 = data).
REQ-002 Parameter NDMW, 2, number of direct-mapped windows.
REQ-003 Parameter NTLB, 8, fully-associative TLB entries, power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 dapg  input  2  mode: 2'b01 direct, 2'b10 mapped, other values treated as direct.
REQ-007 dmw  input  NDMW*32  DMW CSRs: [0] PLV0 enable, [3] PLV3 enable, [5:4] MAT, [27:25] PSEG, [31:29] VSEG.
REQ-008 plv  input  2  current privilege level (0 or 3).
REQ-009 asid  input  10  current ASID.
REQ-010 req_valid / req_ready  input / output  NCH each  per-channel request handshake.
REQ-011 req_vaddr  input  NCH*32  virtual address; req_store  input  NCH  access is a store.
REQ-012 rsp_valid / rsp_ready  output / input  NCH each  per-channel response handshake.
REQ-013 rsp_paddr  output  NCH*32; rsp_uncached  output  NCH; rsp_exc  output  NCH*3  exception code.
REQ-014 tlb_we  input  1; tlb_idx  input  log2(NTLB); tlb_wdata  input  entry struct  TLB write port.
REQ-015 tlb_inv_all  input  1  clear every entry's valid bit.

Function
REQ-016 Each channel is a one-deep registered stage: a request accepted at edge N presents its response from cycle N+1 onward.
REQ-017 req_ready = !rsp_valid || rsp_ready per channel; a response may be consumed and a new request accepted in the same cycle.
REQ-018 rsp_* hold stable while rsp_valid && !rsp_ready; channels never interact or stall each other.
REQ-019 Direct mode: paddr = vaddr, uncached = 0, exc = NONE.
REQ-020 Mapped mode, DMW hit: vaddr[31:29] == VSEG and the plv enable bit is set; paddr = {PSEG, vaddr[28:0]}, uncached = (MAT == 0), exc = NONE; lowest-index window wins.
REQ-021 Mapped mode, no DMW hit: TLB lookup on entries with valid && vppn == vaddr[31:12] && (g || entry asid == asid), 4 KB pages only.
REQ-022 TLB match: paddr = {ppn, vaddr[11:0]}, uncached = (mat == 0); lowest matching index wins.
REQ-023 Exception priority: no match -> TLBR; entry v == 0 -> PIL/PIS (load/store); plv > entry plv -> PPI; store && d == 0 -> PME; otherwise NONE.
REQ-024 On any exception, paddr = vaddr and uncached = 1.
REQ-025 Translation uses mode, CSR and TLB values sampled at the request's accept edge.
REQ-026 A TLB write or invalidate at the same edge as an accept is not visible to that request; it takes effect for accepts from the next edge.
REQ-027 tlb_inv_all takes priority over tlb_we in the same cycle.

Reset
REQ-028 While reset is low at an edge: rsp_valid = 0, rsp_paddr = 0, rsp_uncached = 0, rsp_exc = NONE, all TLB valid bits = 0.
REQ-029 Reset mid-transaction drops a pending response with no handshake.
REQ-030 req_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-031 The shared package holds the TLB entry struct (vppn 20, asid 10, g, v, d, plv 2, mat 2, ppn 20), exception enum (NONE, TLBR, PIL, PIS, PPI, PME) and mode constants.
REQ-032 One sub-module, addr_trans_lookup, is combinational: vaddr plus CSRs plus TLB array -> paddr/uncached/exc, instantiated NCH times.

Verification
REQ-033 Direct mode: dapg=01, vaddr 0x1C00_0000 -> next cycle paddr 0x1C00_0000, uncached 0, exc NONE.
REQ-034 DMW0 = 0xA000_0011 (VSEG 5, PSEG 0, MAT 1, PLV0 enabled), plv 0, vaddr 0xA000_1234 -> paddr 0x0000_1234, uncached 0; same access at plv 3 -> TLBR with an empty TLB.
REQ-035 Write entry 3 (vppn 0x00040, ppn 0x12345, v, d, mat 1, plv 3, g); load from 0x0004_0ABC -> paddr 0x1234_5ABC; with d = 0 a store -> PME; with v = 0 a load -> PIL.
REQ-036 Both channels issue back-to-back for 8 cycles, rsp_ready toggling on channel 1 -> no lost or duplicated responses and held data stable while stalled.
REQ-037 tlb_inv_all in the same cycle as an accepted lookup -> that lookup hits; the next lookup -> TLBR; reset asserted with rsp_valid high -> rsp_valid 0 at the next edge.
